interconnect_datapath_param: RTL and testbench
==============================================

# interconnect_datapath_param

Parametrised banked-memory interconnect datapath between N_PE processing elements and N_BANKS global-memory SRAM banks. It steers arbiter-granted loads and stores, plus a host init port, onto the bank ports. It returns read data through a configurable-latency pipeline with an optional output register. It also adds pipeline flush, detection and reporting of loads dropped by init pre-emption, and a saturating conflict counter.

## Interface
Parameters:
- N_PE, 8: number of PEs; PE_W = $clog2(N_PE).
- N_BANKS, 16: number of banks; BANK_W = $clog2(N_BANKS).
- DATA_L, 32: data width.
- ADDR_L, 10: per-bank address width.
- RD_LATENCY, 1: SRAM read latency in cycles, >= 1.
- OUT_REG, 1: 1 registers and holds ld_data and init_rd_data, adding +1 cycle; 0 uses a combinational mux.
- CNT_W, 16: conflict counter width.

Ports:
- clk in 1: sole clock.
- rst in 1: synchronous, active-high reset.
- ld_bank_id in N_PE×BANK_W: target bank of each PE load.
- ld_bank_addr in N_PE×ADDR_L: load address.
- ld_gnt in N_PE: load granted this cycle.
- st_bank_addr in N_PE×ADDR_L: store address.
- st_data in N_PE×DATA_L: store data.
- bank_gnt_vld in N_BANKS: bank has a granted requester.
- bank_gnt_id in N_BANKS×PE_W: granted PE.
- bank_gnt_st in N_BANKS: 1 = store, 0 = load.
- init_bank_id in BANK_W: host target bank.
- init_bank_addr in ADDR_L: host address.
- init_mem_vld, init_mem_wr_en in 1: host access and its direction.
- init_mem_wr_data in DATA_L: host write data.
- flush in 1: discard all in-flight PE load responses.
- mem_addr out N_BANKS×ADDR_L; mem_wr_data out N_BANKS×DATA_L; mem_wr_en out N_BANKS; mem_rd_en out N_BANKS: bank ports.
- mem_rd_data in N_BANKS×DATA_L: bank read data.
- ld_data out N_PE×DATA_L; ld_data_vld out N_PE: load responses.
- ld_drop out N_PE: pulse marking a pre-empted load.
- init_rd_data out DATA_L; init_rd_data_vld out 1: host read response.
- err_conflict out 1: sticky conflict flag.
- conflict_cnt out CNT_W: saturating count of conflict cycles.

## Operation
- Bank b request side is combinational, with priority init > PE grant > idle:
  - Init: selected when init_mem_vld and init_bank_id==b. Drives the init address; wr_en=init_mem_wr_en; rd_en=~init_mem_wr_en.
  - Store: bank_gnt_vld[b] and bank_gnt_st[b]. Drives st_bank_addr/st_data[bank_gnt_id[b]] with wr_en=1.
  - Load: bank_gnt_vld[b] and !bank_gnt_st[b]. Drives ld_bank_addr[bank_gnt_id[b]] with rd_en=1.
  - Idle: wr_en=rd_en=0; addr and data are don't-care but stable, driven from PE 0.
- Each PE has a RD_LATENCY-deep shift pipe carrying {vld, bank_id, drop}.
  - Entry: vld=ld_gnt[p] & ~flush.
  - drop=ld_gnt[p] & init_mem_vld & (init_bank_id==ld_bank_id[p]).
- Pipe exit:
  - If vld & ~drop, ld_data_vld pulses and ld_data = mem_rd_data[bank_id].
  - If vld & drop, ld_drop pulses, ld_data_vld=0, and ld_data is unchanged.
- flush clears the vld bits of every PE pipe at the same edge. The flush-cycle entry is also discarded. Bank writes are never affected. The init pipe ignores flush.
- Init read pipe: same structure, entry vld=init_mem_vld & ~init_mem_wr_en.
- A conflict cycle is any cycle with either:
  - two or more PEs having ld_gnt=1 and equal ld_bank_id, or
  - any PE load dropped by init pre-emption.
- Each conflict cycle sets err_conflict (sticky until rst) and increments conflict_cnt by 1, saturating at 2^CNT_W-1.
- With OUT_REG=1, ld_data[p] and init_rd_data hold their last valid value until the next valid response.

## Timing
- Bank outputs are combinational: a request in cycle t appears on mem_* in cycle t.
- Load response:
  - ld_data_vld, ld_drop and init_rd_data_vld assert in cycle t+RD_LATENCY+OUT_REG for a grant in cycle t.
  - Each is a one-cycle pulse per request.
  - Back-to-back grants give back-to-back pulses.
- Conflict reporting: err_conflict and conflict_cnt update on the edge that ends the conflict cycle, so they are visible in t+1.
- Reset (synchronous, rst=1 at a rising edge) clears all pipes. Reset values:
  - ld_data_vld=0, ld_drop=0, init_rd_data_vld=0.
  - ld_data=0 and init_rd_data=0 when OUT_REG=1.
  - err_conflict=0, conflict_cnt=0.
- In-flight responses at reset are lost and never emitted.
- flush and rst in the same cycle: reset wins, with identical result.
- flush on the exit cycle: with OUT_REG=1, the registered pulse in that cycle still emits and younger entries are cleared. With OUT_REG=0, the exit output is gated, so no pulse occurs.

## Test plan
- RD_LATENCY=2, OUT_REG=1. PE3 load from bank 5 addr 0x12, with the SRAM model returning 0xCAFE0012 -> ld_data_vld[3]=1 exactly at t+3, ld_data[3]=0xCAFE0012, held afterwards.
- PE1 store 0xDEADBEEF to bank 2 addr 7, then PE0 load from bank 2 addr 7 -> mem_wr_en[2]=1 with correct addr/data in cycle t; the load returns 0xDEADBEEF.
- In one cycle, init read on bank 4 and PE6 load on bank 4 -> bank 4 driven by init (rd_en=1, init addr); init_rd_data_vld at t+RD_LATENCY+OUT_REG; ld_drop[6] pulses at the same cycle; ld_data_vld[6]=0; conflict_cnt=1; err_conflict=1.
- Loads from PE0 and PE1 each cycle for 4 cycles, flush in cycle 2 -> responses only for cycle-0/1 grants that exit before the flush edge, plus the cycle-3 grant; none for cycle 2.
- Force 2^CNT_W+3 conflict cycles (CNT_W=4) -> conflict_cnt sticks at 15.
- Assert rst mid-stream with 3 loads in flight -> no valid pulses after reset; all outputs at reset values.

Source files
------------

// File: rtl/interconnect_datapath_param.sv
// Banked-memory interconnect datapath: steers init/PE requests onto SRAM bank ports
// and returns read data through a per-PE latency-matched pipe with optional output register.
module interconnect_datapath_param #(
  parameter int N_PE       = 8,
  parameter int N_BANKS    = 16,
  parameter int DATA_L     = 32,
  parameter int ADDR_L     = 10,
  parameter int RD_LATENCY = 1,
  parameter int OUT_REG    = 1,
  parameter int CNT_W      = 16,
  localparam int PE_W      = (N_PE > 1) ? $clog2(N_PE) : 1,
  localparam int BANK_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PE-1:0][BANK_W-1:0]     ld_bank_id,
  input  logic [N_PE-1:0][ADDR_L-1:0]     ld_bank_addr,
  input  logic [N_PE-1:0]                 ld_gnt,
  input  logic [N_PE-1:0][ADDR_L-1:0]     st_bank_addr,
  input  logic [N_PE-1:0][DATA_L-1:0]     st_data,
  input  logic [N_BANKS-1:0]              bank_gnt_vld,
  input  logic [N_BANKS-1:0][PE_W-1:0]    bank_gnt_id,
  input  logic [N_BANKS-1:0]              bank_gnt_st,
  input  logic [BANK_W-1:0]               init_bank_id,
  input  logic [ADDR_L-1:0]               init_bank_addr,
  input  logic                            init_mem_vld,
  input  logic                            init_mem_wr_en,
  input  logic [DATA_L-1:0]               init_mem_wr_data,
  input  logic                            flush,
  output logic [N_BANKS-1:0][ADDR_L-1:0]  mem_addr,
  output logic [N_BANKS-1:0][DATA_L-1:0]  mem_wr_data,
  output logic [N_BANKS-1:0]              mem_wr_en,
  output logic [N_BANKS-1:0]              mem_rd_en,
  input  logic [N_BANKS-1:0][DATA_L-1:0]  mem_rd_data,
  output logic [N_PE-1:0][DATA_L-1:0]     ld_data,
  output logic [N_PE-1:0]                 ld_data_vld,
  output logic [N_PE-1:0]                 ld_drop,
  output logic [DATA_L-1:0]               init_rd_data,
  output logic                            init_rd_data_vld,
  output logic                            err_conflict,
  output logic [CNT_W-1:0]                conflict_cnt
);

  // Request side: init pre-empts any PE grant on its bank
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      mem_addr[b]    = ld_bank_addr[0];
      mem_wr_data[b] = st_data[0];
      mem_wr_en[b]   = 1'b0;
      mem_rd_en[b]   = 1'b0;
      if (init_mem_vld && (init_bank_id == BANK_W'(b))) begin
        mem_addr[b]    = init_bank_addr;
        mem_wr_data[b] = init_mem_wr_data;
        mem_wr_en[b]   = init_mem_wr_en;
        mem_rd_en[b]   = ~init_mem_wr_en;
      end else if (bank_gnt_vld[b]) begin
        if (bank_gnt_st[b]) begin
          mem_addr[b]    = st_bank_addr[bank_gnt_id[b]];
          mem_wr_data[b] = st_data[bank_gnt_id[b]];
          mem_wr_en[b]   = 1'b1;
        end else begin
          mem_addr[b]    = ld_bank_addr[bank_gnt_id[b]];
          mem_rd_en[b]   = 1'b1;
        end
      end
    end
  end

  logic [N_PE-1:0] ent_vld, ent_drop;
  logic            same_bank;

  always_comb begin
    same_bank = 1'b0;
    for (int p = 0; p < N_PE; p++) begin
      ent_vld[p]  = ld_gnt[p] & ~flush;
      ent_drop[p] = ld_gnt[p] & init_mem_vld & (init_bank_id == ld_bank_id[p]);
    end
    for (int i = 0; i < N_PE; i++) begin
      for (int j = i + 1; j < N_PE; j++) begin
        if (ld_gnt[i] && ld_gnt[j] && (ld_bank_id[i] == ld_bank_id[j])) same_bank = 1'b1;
      end
    end
  end

  // Response pipes: stage 0 captures the grant, stage RD_LATENCY-1 lines up with SRAM data
  logic [N_PE-1:0][RD_LATENCY-1:0]             pe_vld_q, pe_drop_q;
  logic [N_PE-1:0][RD_LATENCY-1:0][BANK_W-1:0] pe_bank_q;
  logic [RD_LATENCY-1:0]                       ini_vld_q;
  logic [RD_LATENCY-1:0][BANK_W-1:0]           ini_bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_vld_q  <= '0;
      ini_vld_q <= '0;
    end else begin
      ini_vld_q[0] <= init_mem_vld & ~init_mem_wr_en;
      for (int s = 1; s < RD_LATENCY; s++) ini_vld_q[s] <= ini_vld_q[s-1];
      for (int p = 0; p < N_PE; p++) begin
        pe_vld_q[p][0] <= ent_vld[p];
        for (int s = 1; s < RD_LATENCY; s++) pe_vld_q[p][s] <= pe_vld_q[p][s-1] & ~flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    ini_bank_q[0] <= init_bank_id;
    for (int s = 1; s < RD_LATENCY; s++) ini_bank_q[s] <= ini_bank_q[s-1];
    for (int p = 0; p < N_PE; p++) begin
      pe_bank_q[p][0] <= ld_bank_id[p];
      pe_drop_q[p][0] <= ent_drop[p];
      for (int s = 1; s < RD_LATENCY; s++) begin
        pe_bank_q[p][s] <= pe_bank_q[p][s-1];
        pe_drop_q[p][s] <= pe_drop_q[p][s-1];
      end
    end
  end

  logic [N_PE-1:0]             ex_vld, ex_drop;
  logic [N_PE-1:0][DATA_L-1:0] ex_data;
  logic                        ini_ex_vld;
  logic [DATA_L-1:0]           ini_ex_data;

  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      ex_vld[p]  = pe_vld_q[p][RD_LATENCY-1];
      ex_drop[p] = pe_drop_q[p][RD_LATENCY-1];
      ex_data[p] = mem_rd_data[pe_bank_q[p][RD_LATENCY-1]];
    end
    ini_ex_vld  = ini_vld_q[RD_LATENCY-1];
    ini_ex_data = mem_rd_data[ini_bank_q[RD_LATENCY-1]];
  end

  // Output stage: the registered variant captures the exiting entry even under flush
  if (OUT_REG != 0) begin : g_oreg
    logic [N_PE-1:0]             ld_vld_q, ld_drop_q;
    logic [N_PE-1:0][DATA_L-1:0] ld_data_q;
    logic                        ini_rvld_q;
    logic [DATA_L-1:0]           ini_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        ld_vld_q   <= '0;
        ld_drop_q  <= '0;
        ld_data_q  <= '0;
        ini_rvld_q <= 1'b0;
        ini_data_q <= '0;
      end else begin
        ld_vld_q   <= ex_vld & ~ex_drop;
        ld_drop_q  <= ex_vld & ex_drop;
        ini_rvld_q <= ini_ex_vld;
        for (int p = 0; p < N_PE; p++) begin
          if (ex_vld[p] && !ex_drop[p]) ld_data_q[p] <= ex_data[p];
        end
        if (ini_ex_vld) ini_data_q <= ini_ex_data;
      end
    end

    assign ld_data_vld      = ld_vld_q;
    assign ld_drop          = ld_drop_q;
    assign ld_data          = ld_data_q;
    assign init_rd_data_vld = ini_rvld_q;
    assign init_rd_data     = ini_data_q;
  end else begin : g_comb
    assign ld_data_vld      = ex_vld & ~ex_drop & {N_PE{~flush}};
    assign ld_drop          = ex_vld & ex_drop & {N_PE{~flush}};
    assign ld_data          = ex_data;
    assign init_rd_data_vld = ini_ex_vld;
    assign init_rd_data     = ini_ex_data;
  end

  logic             conflict, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign conflict = same_bank | (|ent_drop);
  assign err_d    = err_q | conflict;
  assign cnt_d    = (conflict && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_conflict = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_interconnect_datapath_param.sv
// Directed bench for interconnect_datapath_param (RD_LATENCY=2, OUT_REG=1, CNT_W=4)
// with a behavioural SRAM and a queue-based response scoreboard.
module tb_interconnect_datapath_param;
  localparam int N_PE = 8, N_BANKS = 16, DATA_L = 32, ADDR_L = 10;
  localparam int RL = 2, OREG = 1, CNT_W = 4, LAT = RL + OREG;
  localparam int PE_W = 3, BANK_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           rst;
  logic [N_PE-1:0][BANK_W-1:0]    ld_bank_id;
  logic [N_PE-1:0][ADDR_L-1:0]    ld_bank_addr;
  logic [N_PE-1:0]                ld_gnt;
  logic [N_PE-1:0][ADDR_L-1:0]    st_bank_addr;
  logic [N_PE-1:0][DATA_L-1:0]    st_data;
  logic [N_BANKS-1:0]             bank_gnt_vld;
  logic [N_BANKS-1:0][PE_W-1:0]   bank_gnt_id;
  logic [N_BANKS-1:0]             bank_gnt_st;
  logic [BANK_W-1:0]              init_bank_id;
  logic [ADDR_L-1:0]              init_bank_addr;
  logic                           init_mem_vld, init_mem_wr_en;
  logic [DATA_L-1:0]              init_mem_wr_data;
  logic                           flush;
  logic [N_BANKS-1:0][ADDR_L-1:0] mem_addr;
  logic [N_BANKS-1:0][DATA_L-1:0] mem_wr_data;
  logic [N_BANKS-1:0]             mem_wr_en, mem_rd_en;
  logic [N_BANKS-1:0][DATA_L-1:0] mem_rd_data;
  logic [N_PE-1:0][DATA_L-1:0]    ld_data;
  logic [N_PE-1:0]                ld_data_vld, ld_drop;
  logic [DATA_L-1:0]              init_rd_data;
  logic                           init_rd_data_vld, err_conflict;
  logic [CNT_W-1:0]               conflict_cnt;

  interconnect_datapath_param #(
    .N_PE(N_PE), .N_BANKS(N_BANKS), .DATA_L(DATA_L), .ADDR_L(ADDR_L),
    .RD_LATENCY(RL), .OUT_REG(OREG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_bank_id(ld_bank_id), .ld_bank_addr(ld_bank_addr), .ld_gnt(ld_gnt),
    .st_bank_addr(st_bank_addr), .st_data(st_data),
    .bank_gnt_vld(bank_gnt_vld), .bank_gnt_id(bank_gnt_id), .bank_gnt_st(bank_gnt_st),
    .init_bank_id(init_bank_id), .init_bank_addr(init_bank_addr),
    .init_mem_vld(init_mem_vld), .init_mem_wr_en(init_mem_wr_en),
    .init_mem_wr_data(init_mem_wr_data), .flush(flush),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .ld_data(ld_data), .ld_data_vld(ld_data_vld), .ld_drop(ld_drop),
    .init_rd_data(init_rd_data), .init_rd_data_vld(init_rd_data_vld),
    .err_conflict(err_conflict), .conflict_cnt(conflict_cnt)
  );

  // SRAM model: unwritten words return a fixed per-bank/address pattern
  bit [31:0] sram [N_BANKS][1024];
  bit        wr_mask [N_BANKS][1024];
  logic [N_BANKS-1:0][DATA_L-1:0] rd_q1, rd_q2;

  function automatic logic [31:0] dflt(int b, int a);
    if (b == 5 && a == 'h12) return 32'hCAFE0012;
    return 32'hB000_0000 | (32'(b) << 16) | 32'(a);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (mem_wr_en[b]) begin
        sram[b][mem_addr[b]]    <= mem_wr_data[b];
        wr_mask[b][mem_addr[b]] <= 1'b1;
      end
      if (mem_rd_en[b])
        rd_q1[b] <= wr_mask[b][mem_addr[b]] ? sram[b][mem_addr[b]] : dflt(b, int'(mem_addr[b]));
    end
    rd_q2 <= rd_q1;
  end
  assign mem_rd_data = rd_q2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int pe; logic [31:0] data; int cyc; } exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = load data, 1 = load drop, 2 = init read
  task automatic push(input int kind, input int pe, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.pe = pe; e.data = data; e.cyc = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic expect_evt(input int kind, input int pe, input logic [31:0] data);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_evt: kind %0d pe %0d data %h at cycle %0d, expected none", kind, pe, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.pe != pe || e.cyc != cyc || e.data !== data) begin
        fails++;
        $display("FAIL resp: got kind %0d pe %0d data %h cycle %0d, expected kind %0d pe %0d data %h cycle %0d",
                 kind, pe, data, cyc, e.kind, e.pe, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_resp: kind %0d pe %0d data %h expected at cycle %0d, none by %0d",
                 q[0].kind, q[0].pe, q[0].data, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (init_rd_data_vld) expect_evt(2, 0, init_rd_data);
      for (int p = 0; p < N_PE; p++) begin
        if (ld_data_vld[p]) expect_evt(0, p, ld_data[p]);
        if (ld_drop[p])     expect_evt(1, p, ld_data[p]);
      end
    end
  end

  task automatic clear_in();
    ld_bank_id = '0; ld_bank_addr = '0; ld_gnt = '0;
    st_bank_addr = '0; st_data = '0;
    bank_gnt_vld = '0; bank_gnt_id = '0; bank_gnt_st = '0;
    init_bank_id = '0; init_bank_addr = '0; init_mem_vld = 1'b0;
    init_mem_wr_en = 1'b0; init_mem_wr_data = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic ld(input int p, input int b, input int a);
    ld_gnt[p]       = 1'b1;
    ld_bank_id[p]   = BANK_W'(b);
    ld_bank_addr[p] = ADDR_L'(a);
    bank_gnt_vld[b] = 1'b1;
    bank_gnt_id[b]  = PE_W'(p);
    bank_gnt_st[b]  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_ld_vld",   {56'b0, ld_data_vld}, 64'h0);
    check("rst_ld_drop",  {56'b0, ld_drop}, 64'h0);
    check("rst_init_vld", {63'b0, init_rd_data_vld}, 64'h0);
    check("rst_ld_data",  {63'b0, |ld_data}, 64'h0);
    check("rst_err_cnt",  {59'b0, err_conflict, conflict_cnt}, 64'h0);

    // PE3 load, bank 5 addr 0x12
    step();
    ld(3, 5, 'h12);
    push(0, 3, 32'hCAFE0012);
    #1;
    check("ld_rd_en5",  {63'b0, mem_rd_en[5]}, 64'h1);
    check("ld_addr5",   {54'b0, mem_addr[5]}, 64'h12);
    check("ld_wr_en5",  {63'b0, mem_wr_en[5]}, 64'h0);
    check("idle_en9",   {62'b0, mem_rd_en[9], mem_wr_en[9]}, 64'h0);
    repeat (5) step();
    check("hold_ld3",   {32'b0, ld_data[3]}, 64'hCAFE0012);
    check("hold_vld3",  {63'b0, ld_data_vld[3]}, 64'h0);

    // PE1 store then PE0 load of the same word
    step();
    bank_gnt_vld[2] = 1'b1; bank_gnt_id[2] = 3'd1; bank_gnt_st[2] = 1'b1;
    st_bank_addr[1] = 10'd7; st_data[1] = 32'hDEADBEEF;
    #1;
    check("st_wr_en2",  {63'b0, mem_wr_en[2]}, 64'h1);
    check("st_rd_en2",  {63'b0, mem_rd_en[2]}, 64'h0);
    check("st_addr2",   {54'b0, mem_addr[2]}, 64'h7);
    check("st_data2",   {32'b0, mem_wr_data[2]}, 64'hDEADBEEF);
    step();
    ld(0, 2, 7);
    push(0, 0, 32'hDEADBEEF);
    #1;
    check("ld_rd_en2",  {63'b0, mem_rd_en[2]}, 64'h1);
    repeat (5) step();

    // Init read pre-empts PE6 on bank 4
    step();
    init_mem_vld = 1'b1; init_mem_wr_en = 1'b0; init_bank_id = 4'd4; init_bank_addr = 10'h20;
    ld(6, 4, 'h30);
    push(2, 0, 32'hB0040020);
    push(1, 6, 32'h0);
    #1;
    check("init_addr4",  {54'b0, mem_addr[4]}, 64'h20);
    check("init_rd_en4", {63'b0, mem_rd_en[4]}, 64'h1);
    check("init_wr_en4", {63'b0, mem_wr_en[4]}, 64'h0);
    check("cnt_before",  {60'b0, conflict_cnt}, 64'h0);
    step();
    check("cnt_after_drop", {60'b0, conflict_cnt}, 64'h1);
    check("err_after_drop", {63'b0, err_conflict}, 64'h1);
    repeat (5) step();

    // Loads each cycle for 4 cycles, flush on the third: only the oldest
    // (already at pipe exit) and the post-flush grant respond
    for (int c = 0; c < 4; c++) begin
      step();
      ld(0, 0, c);
      ld(1, 1, c);
      if (c == 2) flush = 1'b1;
      if (c == 0 || c == 3) begin
        push(0, 0, 32'hB0000000 | 32'(c));
        push(0, 1, 32'hB0010000 | 32'(c));
      end
    end
    repeat (6) step();

    // Same-bank conflicts until the 4-bit counter saturates
    for (int i = 0; i < 14; i++) begin
      step();
      ld(0, 7, 0);
      ld(1, 7, 0);
      push(0, 0, 32'hB0070000);
      push(0, 1, 32'hB0070000);
    end
    step();
    check("cnt_at_max", {60'b0, conflict_cnt}, 64'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      ld(0, 7, 0);
      ld(1, 7, 0);
      push(0, 0, 32'hB0070000);
      push(0, 1, 32'hB0070000);
    end
    step();
    check("cnt_saturated", {60'b0, conflict_cnt}, 64'hF);
    check("err_sticky",    {63'b0, err_conflict}, 64'h1);
    repeat (5) step();

    // Reset with three loads in flight: nothing may emerge afterwards
    step();
    ld(2, 3, 0);
    step();
    ld(2, 3, 1);
    step();
    ld(2, 3, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld",   {56'b0, ld_data_vld}, 64'h0);
    check("mid_rst_drop",  {56'b0, ld_drop}, 64'h0);
    check("mid_rst_ivld",  {63'b0, init_rd_data_vld}, 64'h0);
    check("mid_rst_data",  {63'b0, |ld_data}, 64'h0);
    check("mid_rst_idata", {32'b0, init_rd_data}, 64'h0);
    check("mid_rst_cnt",   {60'b0, conflict_cnt}, 64'h0);
    check("mid_rst_err",   {63'b0, err_conflict}, 64'h0);
    repeat (8) step();

    check("queue_empty", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
